// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Encode a one-hot requester vector; returns 0 for an all-zero input.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_4_1_arbiter_rr_pick4.sv
// Combinational round-robin picker: priority ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_masked,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] win_idx,
  output logic [NREQ-1:0]  win_oh
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found  = |req_masked;
    win_oh = '0;
    cand   = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req_masked[cand]) win_oh = NREQ'(1) << cand;
    end
    win_idx = onehot_to_idx(win_oh);
  end

endmodule

// File: rtl/mux_4_1_arbiter.sv
// Round-robin burst arbiter driving the select of a shared 4:1 mux.
module mux_4_1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  last,
  input  logic             out_ready,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             out_last
);

  localparam bit         CAP_EN   = (MAX_BEATS != 0);
  localparam logic [7:0] CAP_LAST = (MAX_BEATS == 0) ? 8'd0 : 8'(MAX_BEATS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             active;
  logic [NREQ-1:0]  owner_oh;
  logic             owner_req, owner_last;
  logic             xfer, rel_last, rel_cap, rel_drop, rel;
  logic [NREQ-1:0]  pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] win_idx;
  logic [NREQ-1:0]  win_oh;

  assign active     = (state_q == GRANT);
  assign owner_oh   = NREQ'(1) << owner_q;
  assign owner_req  = req[owner_q];
  assign owner_last = last[owner_q];
  assign xfer       = active && owner_req && out_ready;
  assign rel_last   = xfer && owner_last;
  assign rel_cap    = xfer && CAP_EN && (cnt_q == CAP_LAST);
  assign rel_drop   = active && !owner_req;
  assign rel        = rel_last || rel_cap || rel_drop;

  // On release the picker already sees the updated pointer (owner), so a
  // still-requesting owner naturally falls to lowest priority; only a
  // finished burst removes the owner from the candidate set.
  assign pick_req = rel_last ? (req & ~owner_oh) : req;
  assign pick_ptr = active ? owner_q : ptr_q;

  rr_pick4 u_pick (
    .req_masked (pick_req),
    .ptr        (pick_ptr),
    .found      (found),
    .win_idx    (win_idx),
    .win_oh     (win_oh)
  );

  // State, owner, priority pointer and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitrate from IDLE, or hand over without a bubble on release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = owner_q;
          cnt_d = '0;
          if (found) owner_d = win_idx;
          else       state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; req/last only gate the valids.
  always_comb begin
    grant     = active ? owner_oh : '0;
    sel       = active ? owner_q : '0;
    out_valid = active && owner_req;
    out_last  = out_valid && owner_last;
  end

endmodule
